// File: rtl/state_log_pkg.sv
// Shared types and constants for the state-log readout controller.
package state_log_pkg;

   typedef enum logic [1:0] {StIdle, StGrant, StSend, StClear} state_e;

   // Word index as presented on oRdIdx, newest first
   localparam logic [1:0] IDX_CUR   = 2'd0;
   localparam logic [1:0] IDX_PREV2 = 2'd1;
   localparam logic [1:0] IDX_PREV1 = 2'd2;
   localparam logic [1:0] IDX_PREV0 = 2'd3;

   // Requester ids, also bit positions in the arbiter request/grant vectors
   localparam int unsigned REQ_A = 0;
   localparam int unsigned REQ_B = 1;

   // Position of a word inside a packed {cur,prev2,prev1,prev0} group, counted from the LSB word
   function automatic int unsigned word_pos(input logic [1:0] idx);
      int unsigned pos;
      unique case (idx)
         IDX_CUR:   pos = 3;
         IDX_PREV2: pos = 2;
         IDX_PREV1: pos = 1;
         default:   pos = 0;
      endcase
      return pos;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. On contention the requester not served last wins;
// the preference only moves when a grant is actually taken (iUpdate).
module rr_arb2 import state_log_pkg::*; (
   input  logic       iClk,
   input  logic       iRst,
   input  logic [1:0] iReq,
   input  logic       iUpdate,
   output logic [1:0] oGnt
);

   logic prio_q, prio_d;  // 0: A preferred, 1: B preferred

   // One-hot grant from current requests and preference
   always_comb begin
      oGnt = iReq;
      if (iReq[REQ_A] && iReq[REQ_B]) begin
         oGnt = prio_q ? 2'b10 : 2'b01;
      end
   end

   // After serving A prefer B, and vice versa
   always_comb begin
      prio_d = prio_q;
      if (iUpdate && (oGnt != 2'b00)) begin
         prio_d = oGnt[REQ_A];
      end
   end

   // Preference register, resets to favour A
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/state_log_readout_ctrl.sv
// Readout sequencer for CH_NUM state-history loggers shared by two requesters.
// Grants round-robin, snapshots the chosen channel, streams 4 words newest first with
// backpressure, then optionally pulses the logger clear.
// Optional build macro: STATE_LOG_TIMEOUT_EN adds a backpressure abort after TIMEOUT_CYC
// consecutive stalled cycles.
module state_log_readout_ctrl import state_log_pkg::*; #(
   parameter int unsigned CH_NUM      = 4,
   parameter int unsigned CH_IDX_W    = 2,
   parameter int unsigned BITS        = 8,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic                     iReqA,
   input  logic                     iReqB,
   input  logic [CH_IDX_W-1:0]      iChA,
   input  logic [CH_IDX_W-1:0]      iChB,
   input  logic                     iClrA,
   input  logic                     iClrB,
   input  logic [CH_NUM*4*BITS-1:0] iLogData,
   input  logic                     iRdReady,
   output logic                     oGntA,
   output logic                     oGntB,
   output logic                     oRdValid,
   output logic [BITS-1:0]          oRdData,
   output logic [1:0]               oRdIdx,
   output logic                     oRdLast,
   output logic                     oRdErr,
   output logic [CH_NUM-1:0]        oLogClear,
   output logic                     oBusy
);

   state_e              state_q, state_d;
   logic                win_q, win_d;    // 1: B owns the current transfer
   logic [CH_IDX_W-1:0] ch_q, ch_d;
   logic                clr_q, clr_d;
   logic                err_q, err_d;    // channel index out of range
   logic [4*BITS-1:0]   snap_q, snap_d;
   logic [1:0]          idx_q, idx_d;

   logic [1:0]          req;
   logic [1:0]          gnt;
   logic                arb_upd;
   logic [CH_IDX_W-1:0] ch_sel;
   logic                clr_sel;
   logic                sel_valid;
   logic [4*BITS-1:0]   snap_sel;
   logic                abort;

   assign req     = {iReqB, iReqA};
   assign arb_upd = (state_q == StIdle) && (req != 2'b00);

   rr_arb2 u_arb (
      .iClk    (iClk),
      .iRst    (iRst),
      .iReq    (req),
      .iUpdate (arb_upd),
      .oGnt    (gnt)
   );

   // Channel, clear flag and logger words of whichever requester the arbiter picks
   always_comb begin
      ch_sel    = gnt[REQ_B] ? iChB : iChA;
      clr_sel   = gnt[REQ_B] ? iClrB : iClrA;
      sel_valid = 32'(ch_sel) < CH_NUM;
      snap_sel  = '0;
      for (int unsigned c = 0; c < CH_NUM; c++) begin
         if (32'(ch_sel) == c) begin
            snap_sel = iLogData[c*4*BITS +: 4*BITS];
         end
      end
   end

`ifdef STATE_LOG_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

   logic [TmoW-1:0] tmo_q, tmo_d;

   // Count consecutive stalled SEND cycles; the TIMEOUT_CYC-th stall aborts the transfer
   always_comb begin
      tmo_d = '0;
      abort = 1'b0;
      if ((state_q == StSend) && !iRdReady) begin
         tmo_d = tmo_q + 1'b1;
         abort = (tmo_q == TmoW'(TIMEOUT_CYC - 1));
      end
   end

   // Stall counter register
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYC;
   assign abort      = 1'b0;
`endif

   // Next-state logic: latch winner and snapshot on grant, step words on accept
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      ch_d    = ch_q;
      clr_d   = clr_q;
      err_d   = err_q;
      snap_d  = snap_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (req != 2'b00) begin
               state_d = StGrant;
               win_d   = gnt[REQ_B];
               ch_d    = ch_sel;
               clr_d   = clr_sel;
               err_d   = !sel_valid;
               snap_d  = snap_sel;  // already zero for an invalid channel
               idx_d   = IDX_CUR;
            end
         end
         StGrant: state_d = StSend;
         StSend: begin
            if (abort) begin
               state_d = StIdle;
            end else if (iRdReady) begin
               if (idx_q == IDX_PREV0) begin
                  state_d = (clr_q && !err_q) ? StClear : StIdle;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         StClear: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from registered state only; all zero in IDLE
   always_comb begin
      oGntA     = 1'b0;
      oGntB     = 1'b0;
      oRdValid  = 1'b0;
      oRdData   = '0;
      oRdIdx    = '0;
      oRdLast   = 1'b0;
      oRdErr    = 1'b0;
      oLogClear = '0;
      oBusy     = (state_q != StIdle);
      if (state_q == StGrant) begin
         oGntA = !win_q;
         oGntB = win_q;
      end
      if (state_q == StSend) begin
         oRdValid = 1'b1;
         oRdData  = snap_q[word_pos(idx_q)*BITS +: BITS];
         oRdIdx   = idx_q;
         oRdLast  = (idx_q == IDX_PREV0);
         oRdErr   = err_q;
      end
      for (int unsigned c = 0; c < CH_NUM; c++) begin
         oLogClear[c] = (state_q == StClear) && (32'(ch_q) == c);
      end
   end

   // State registers; async reset drops any transfer without issuing a clear
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= StIdle;
         win_q   <= 1'b0;
         ch_q    <= '0;
         clr_q   <= 1'b0;
         err_q   <= 1'b0;
         snap_q  <= '0;
         idx_q   <= IDX_CUR;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         ch_q    <= ch_d;
         clr_q   <= clr_d;
         err_q   <= err_d;
         snap_q  <= snap_d;
         idx_q   <= idx_d;
      end
   end

endmodule
